// File: rtl/rca_pkg.sv
// Shared definitions for the ripple-carry batch accumulator: datapath widths
// and the controller state encoding.
package rca_pkg;

    localparam int DATA_W = 4;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/RCA_design.sv
// Existing combinational 4-bit ripple-carry adder with bit-level ports.
// S = A + B + Cin, Cout is the carry out of bit 3.
module RCA_design (
    input  logic A0,
    input  logic A1,
    input  logic A2,
    input  logic A3,
    input  logic B0,
    input  logic B1,
    input  logic B2,
    input  logic B3,
    input  logic Cin,
    output logic S0,
    output logic S1,
    output logic S2,
    output logic S3,
    output logic Cout
);

    logic c1, c2, c3;

    assign S0   = A0 ^ B0 ^ Cin;
    assign c1   = (A0 & B0) | (Cin & (A0 ^ B0));
    assign S1   = A1 ^ B1 ^ c1;
    assign c2   = (A1 & B1) | (c1 & (A1 ^ B1));
    assign S2   = A2 ^ B2 ^ c2;
    assign c3   = (A2 & B2) | (c2 & (A2 ^ B2));
    assign S3   = A3 ^ B3 ^ c3;
    assign Cout = (A3 & B3) | (c3 & (A3 ^ B3));

endmodule

// File: rtl/rca_batch_accumulator.sv
// Accumulates N_OPS 4-bit operands through RCA_design (mod 16, carry-outs
// counted) and presents each batch result on a valid/ready output port.
module rca_batch_accumulator
    import rca_pkg::*;
#(
    parameter int N_OPS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic [CNT_W-1:0]  out_carry_cnt,
    output logic              out_ovf
);

    generate
        if (N_OPS < 1 || N_OPS > 15) begin : g_bad_n_ops
            $error("rca_batch_accumulator: N_OPS must be in 1..15");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(N_OPS);

    state_t             state;
    logic [DATA_W-1:0]  acc;
    logic [DATA_W-1:0]  sum;
    logic               cout;
    logic [CNT_W-1:0]   op_cnt;
    logic [CNT_W-1:0]   carry_cnt;
    logic [CNT_W-1:0]   carry_nxt;
    logic               accept;

    RCA_design u_rca (
        .A0  (in_data[0]),
        .A1  (in_data[1]),
        .A2  (in_data[2]),
        .A3  (in_data[3]),
        .B0  (acc[0]),
        .B1  (acc[1]),
        .B2  (acc[2]),
        .B3  (acc[3]),
        .Cin (1'b0),
        .S0  (sum[0]),
        .S1  (sum[1]),
        .S2  (sum[2]),
        .S3  (sum[3]),
        .Cout(cout)
    );

    // in_ready must never look at in_valid, so the source may wait on it.
    assign in_ready  = (state == ST_ACCUM) && en;
    assign out_valid = (state == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign carry_nxt = carry_cnt + {{(CNT_W-1){1'b0}}, cout};

    // NOTE: sequential state uses non-blocking assignments only, and the async
    // reset clears every register so outputs fall the moment rst_n drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            acc           <= '0;
            op_cnt        <= '0;
            carry_cnt     <= '0;
            out_sum       <= '0;
            out_carry_cnt <= '0;
            out_ovf       <= 1'b0;
        end else if (clear) begin
            state         <= en ? ST_ACCUM : ST_IDLE;
            acc           <= '0;
            op_cnt        <= '0;
            carry_cnt     <= '0;
            out_sum       <= '0;
            out_carry_cnt <= '0;
            out_ovf       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (en) state <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc       <= sum;
                        carry_cnt <= carry_nxt;
                        op_cnt    <= op_cnt + 1'b1;
                        if (op_cnt + 1'b1 == LAST_OP) begin
                            state         <= ST_DONE;
                            out_sum       <= sum;
                            out_carry_cnt <= carry_nxt;
                            out_ovf       <= (carry_nxt != '0);
                        end
                    end
                end
                ST_DONE: begin
                    // Result is held until consumed; en is ignored here.
                    if (out_ready) begin
                        acc       <= '0;
                        op_cnt    <= '0;
                        carry_cnt <= '0;
                        state     <= en ? ST_ACCUM : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
